// File: rtl/sa_result_uart_framer_pkg.sv
// Shared constants for the systolic-array result framer: default byte format
// and the FSM state encoding.
package sa_pkg;

  localparam int         DEF_W_DATA    = 8;
  localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_SYNC = 3'd1;
  localparam logic [2:0] ST_WAIT = 3'd2;
  localparam logic [2:0] ST_LOAD = 3'd3;
  localparam logic [2:0] ST_BYTE = 3'd4;
  localparam logic [2:0] ST_CSUM = 3'd5;

  // Counter width that stays legal when the count range collapses to one value.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sa_result_uart_framer_if.sv
// Result-word valid/ready stream from the systolic-array output FIFOs.
interface sa_result_uart_framer_if #(
  parameter int W_WORD = 32
);

  logic [W_WORD-1:0] word;
  logic              word_valid;
  logic              word_ready;

  modport master (output word, output word_valid, input word_ready);
  modport slave  (input word, input word_valid, output word_ready);

endinterface

// File: rtl/sa_result_uart_framer_byte_shift_unloader.sv
// Holds one result word and hands it out W_DATA bits at a time, LSB first,
// tracking which byte of the word is currently at the bottom.
module byte_shift_unloader
  import sa_pkg::*;
#(
  parameter int W_WORD = 32,
  parameter int W_DATA = DEF_W_DATA
) (
  input  logic              i_clk,
  input  logic              i_Rst_L,
  input  logic              clear,
  input  logic              load,
  input  logic              shift,
  input  logic [W_WORD-1:0] load_word,
  output logic [W_DATA-1:0] low_byte,
  output logic              last_byte
);

  localparam int BPW = W_WORD / W_DATA;
  localparam int CW  = clog2_min1(BPW);

  logic [W_WORD-1:0] shreg_reg, shreg_next;
  logic [CW-1:0]     cnt_reg, cnt_next;

  always_comb begin
    shreg_next = shreg_reg;
    cnt_next   = cnt_reg;
    if (clear) begin
      shreg_next = '0;
      cnt_next   = '0;
    end else if (load) begin
      shreg_next = load_word;
      cnt_next   = '0;
    end else if (shift) begin
      shreg_next = shreg_reg >> W_DATA;
      cnt_next   = cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      shreg_reg <= '0;
      cnt_reg   <= '0;
    end else begin
      shreg_reg <= shreg_next;
      cnt_reg   <= cnt_next;
    end
  end

  // The byte counter names the byte now at the bottom of the register.
  assign low_byte  = shreg_reg[W_DATA-1:0];
  assign last_byte = (cnt_reg == CW'(BPW - 1));

endmodule

// File: rtl/sa_result_uart_framer.sv
// Frames N_WORDS result words as SYNC, payload bytes (LSB first), XOR checksum
// and paces each byte into uart_tx on the previous byte's done pulse.
module sa_result_uart_framer
  import sa_pkg::*;
#(
  parameter int                W_WORD    = 32,
  parameter int                W_DATA    = DEF_W_DATA,
  parameter int                N_WORDS   = 64,
  parameter logic [W_DATA-1:0] SYNC_BYTE = W_DATA'(DEF_SYNC_BYTE)
) (
  input  logic                     i_clk,
  input  logic                     i_Rst_L,
  sa_result_uart_framer_if.slave   word_if,
  output logic                     o_tx_dv,
  output logic [W_DATA-1:0]        o_tx_byte,
  input  logic                     i_tx_done,
  output logic                     o_busy,
  output logic                     o_frame_done
);

  localparam int WCW = $clog2(N_WORDS + 1);

  logic [2:0]        state_reg, state_next;
  logic [2:0]        ret_reg, ret_next;
  logic [WCW-1:0]    word_cnt_reg, word_cnt_next;
  logic [W_DATA-1:0] csum_reg, csum_next;
  logic [W_DATA-1:0] tx_byte_reg, tx_byte_next;
  logic              frame_done_reg, frame_done_next;

  logic              clear, load, shift;
  logic [W_DATA-1:0] low_byte;
  logic              last_byte;

  byte_shift_unloader #(
    .W_WORD (W_WORD),
    .W_DATA (W_DATA)
  ) u_unloader (
    .i_clk     (i_clk),
    .i_Rst_L   (i_Rst_L),
    .clear     (clear),
    .load      (load),
    .shift     (shift),
    .load_word (word_if.word),
    .low_byte  (low_byte),
    .last_byte (last_byte)
  );

  always_comb begin
    state_next      = state_reg;
    ret_next        = ret_reg;
    word_cnt_next   = word_cnt_reg;
    csum_next       = csum_reg;
    tx_byte_next    = tx_byte_reg;
    frame_done_next = 1'b0;
    clear           = 1'b0;
    load            = 1'b0;
    shift           = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        clear         = 1'b1;
        word_cnt_next = '0;
        csum_next     = '0;
        if (word_if.word_valid) begin
          state_next   = ST_SYNC;
          tx_byte_next = SYNC_BYTE;
        end
      end
      ST_SYNC: begin
        state_next = ST_WAIT;
        ret_next   = ST_LOAD;
      end
      ST_WAIT: begin
        // The launch byte is registered on the way out of WAIT so it is
        // already stable in the cycle that o_tx_dv is high.
        if (i_tx_done) begin
          state_next = ret_reg;
          if (ret_reg == ST_BYTE) tx_byte_next = low_byte;
          if (ret_reg == ST_CSUM) tx_byte_next = csum_reg;
          if (ret_reg == ST_IDLE) frame_done_next = 1'b1;
        end
      end
      ST_LOAD: begin
        if (word_if.word_valid) begin
          load          = 1'b1;
          word_cnt_next = word_cnt_reg + 1'b1;
          tx_byte_next  = word_if.word[W_DATA-1:0];
          state_next    = ST_BYTE;
        end
      end
      ST_BYTE: begin
        shift      = 1'b1;
        csum_next  = csum_reg ^ low_byte;
        state_next = ST_WAIT;
        if (!last_byte)                         ret_next = ST_BYTE;
        else if (word_cnt_reg < WCW'(N_WORDS))  ret_next = ST_LOAD;
        else                                    ret_next = ST_CSUM;
      end
      ST_CSUM: begin
        state_next = ST_WAIT;
        ret_next   = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_reg      <= ST_IDLE;
      ret_reg        <= ST_IDLE;
      word_cnt_reg   <= '0;
      csum_reg       <= '0;
      tx_byte_reg    <= '0;
      frame_done_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      ret_reg        <= ret_next;
      word_cnt_reg   <= word_cnt_next;
      csum_reg       <= csum_next;
      tx_byte_reg    <= tx_byte_next;
      frame_done_reg <= frame_done_next;
    end
  end

  assign o_tx_dv            = (state_reg == ST_SYNC) || (state_reg == ST_BYTE) ||
                              (state_reg == ST_CSUM);
  assign o_tx_byte          = tx_byte_reg;
  assign o_busy             = (state_reg != ST_IDLE);
  assign o_frame_done       = frame_done_reg;
  assign word_if.word_ready = (state_reg == ST_LOAD);

endmodule
